pwm_duty_feeder: RTL and testbench

- Upstream sequencer for the binary-weighted PWM stage.
- Buffers a queue of duty words written by the host/fabric.
- Drives the PWM's go/duty inputs and holds duty stable for exactly one PWM period.
- Uses the PWM's done pulse to advance to the next queued duty word, with an optional idle gap (go low) between periods.

---
 rtl/pwm_duty_feeder.sv | 180 ++++++++++++++++++
 tb/tb_pwm_duty_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_feeder.sv
// Duty-word sequencer for the binary-weighted PWM: queues host duty words and
// presents one per PWM period, advancing on the PWM's done pulse.
module pwm_duty_feeder #(
    parameter int NO_BITS    = 16,
    parameter int DEPTH_LOG2 = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [NO_BITS-1:0]    wr_duty,
    input  logic                  repeat_last,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  busy,
    output logic                  pwm_go,
    output logic [NO_BITS-1:0]    pwm_duty,
    input  logic                  pwm_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL   = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [7:0]            GAP_RELOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NO_BITS-1:0]      fifo_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q, level_d;
    logic                    full_q, full_d;
    logic                    overflow_q, overflow_d;
    logic                    underrun_q, underrun_d;
    logic                    busy_q, busy_d;
    logic                    go_q, go_d;
    logic [NO_BITS-1:0]      duty_q, duty_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        go_d       = go_q;
        duty_d     = duty_q;
        gap_cnt_d  = gap_cnt_q;
        underrun_d = 1'b0;
        pop        = 1'b0;

        // full is the registered flag, so a pop in this cycle never frees room for this write
        push       = wr_en && !full_q;
        fifo_empty = (level_q == '0);
        overflow_d = overflow_q | (wr_en & full_q);

        case (state_q)
            ST_IDLE: begin
                go_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    go_d    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pwm_done) begin
                    if (GAP_CYCLES == 0) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else if (!repeat_last) begin
                            underrun_d = 1'b1;
                            go_d       = 1'b0;
                            state_d    = ST_IDLE;
                        end
                    end else if (fifo_empty && !repeat_last) begin
                        underrun_d = 1'b1;
                        go_d       = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        go_d      = 1'b0;
                        gap_cnt_d = GAP_RELOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                // FIFO state is re-sampled when the gap expires, not at the done pulse
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    go_d    = 1'b1;
                    state_d = ST_RUN;
                end else if (repeat_last) begin
                    go_d    = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    underrun_d = 1'b1;
                    go_d       = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                go_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            duty_d   = fifo_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        full_d = (level_d == LVL_FULL);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wr_duty;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
            go_q       <= 1'b0;
            duty_q     <= '0;
            gap_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
            go_q       <= go_d;
            duty_q     <= duty_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign full     = full_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;
    assign busy     = busy_q;
    assign pwm_go   = go_q;
    assign pwm_duty = duty_q;

endmodule

// File: tb/tb_pwm_duty_feeder.sv
// Bench for pwm_duty_feeder: directed scenarios on a back-to-back and a gapped
// instance, plus randomized traffic against a queue-based reference model.
module tb_pwm_duty_feeder;

    logic       clock = 1'b0;
    logic       reset;
    // back-to-back instance (GAP_CYCLES = 0)
    logic       wr_en, repeat_last, done;
    logic [3:0] wr_duty;
    logic       full, overflow, underrun, busy, go;
    logic [2:0] level;
    logic [3:0] duty;
    // gapped instance (GAP_CYCLES = 5)
    logic       g_wr_en, g_repeat, g_done;
    logic [3:0] g_wr_duty;
    logic       g_full, g_overflow, g_underrun, g_busy, g_go;
    logic [2:0] g_level;
    logic [3:0] g_duty;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] seq [3];

    always #5 clock = ~clock;

    pwm_duty_feeder #(.NO_BITS(4), .DEPTH_LOG2(2), .GAP_CYCLES(0)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_duty(wr_duty),
        .repeat_last(repeat_last), .full(full), .level(level), .overflow(overflow),
        .underrun(underrun), .busy(busy), .pwm_go(go), .pwm_duty(duty), .pwm_done(done)
    );

    pwm_duty_feeder #(.NO_BITS(4), .DEPTH_LOG2(2), .GAP_CYCLES(5)) dut_gap (
        .clock(clock), .reset(reset), .wr_en(g_wr_en), .wr_duty(g_wr_duty),
        .repeat_last(g_repeat), .full(g_full), .level(g_level), .overflow(g_overflow),
        .underrun(g_underrun), .busy(g_busy), .pwm_go(g_go), .pwm_duty(g_duty), .pwm_done(g_done)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; wr_en = 1'b0; wr_duty = 4'd0; repeat_last = 1'b0; done = 1'b0;
        g_wr_en = 1'b0; g_wr_duty = 4'd0; g_repeat = 1'b0; g_done = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b1; wr_duty = 4'd5; done = 1'b1;
        tick; tick;
        n_checks++; if (go !== 1'b0) $display("FAIL reset_go got=%0b exp=0", go); else n_pass++;
        n_checks++; if (duty !== 4'd0) $display("FAIL reset_duty got=%0d exp=0", duty); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%0b exp=0", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%0b exp=0", overflow); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_und got=%0b exp=0", underrun); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if ({g_go, g_busy, g_full, g_overflow, g_underrun} !== 5'b0)
            $display("FAIL reset_gap_flags got=%05b exp=00000", {g_go, g_busy, g_full, g_overflow, g_underrun});
        else n_pass++;
        n_checks++; if (g_level !== 3'd0) $display("FAIL reset_gap_level got=%0d exp=0", g_level); else n_pass++;
        do_reset;
    endtask

    task automatic test_stream;
        bit go_dropped = 1'b0;
        bit duty_bad   = 1'b0;
        seq[0] = 4'd3; seq[1] = 4'd7; seq[2] = 4'd12;
        do_reset;
        wr_en = 1'b1; wr_duty = 4'd3; tick;
        wr_duty = 4'd7; tick;
        n_checks++; if (go !== 1'b1) $display("FAIL stream_first_go got=%0b exp=1", go); else n_pass++;
        n_checks++; if (duty !== 4'd3) $display("FAIL stream_first_duty got=%0d exp=3", duty); else n_pass++;
        wr_duty = 4'd12; tick;
        wr_en = 1'b0;
        n_checks++; if (level !== 3'd2) $display("FAIL stream_level got=%0d exp=2", level); else n_pass++;
        for (int p = 0; p < 3; p++) begin
            repeat ((p == 0) ? 15 : 16) begin
                tick;
                if (go !== 1'b1) go_dropped = 1'b1;
                if (duty !== seq[p]) duty_bad = 1'b1;
            end
            done = 1'b1; tick; done = 1'b0;
            if (p < 2) begin
                n_checks++; if (duty !== seq[p+1]) $display("FAIL stream_next_duty p=%0d got=%0d exp=%0d", p, duty, seq[p+1]); else n_pass++;
                n_checks++; if (go !== 1'b1) $display("FAIL stream_go_hold p=%0d got=%0b exp=1", p, go); else n_pass++;
            end
        end
        n_checks++; if (underrun !== 1'b1) $display("FAIL stream_underrun got=%0b exp=1", underrun); else n_pass++;
        n_checks++; if (go !== 1'b0) $display("FAIL stream_stop_go got=%0b exp=0", go); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL stream_stop_busy got=%0b exp=0", busy); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL stream_stop_level got=%0d exp=0", level); else n_pass++;
        n_checks++; if (go_dropped !== 1'b0) $display("FAIL stream_go_continuous got=dropped exp=steady"); else n_pass++;
        n_checks++; if (duty_bad !== 1'b0) $display("FAIL stream_duty_stable got=changed exp=held"); else n_pass++;
        tick;
        n_checks++; if (underrun !== 1'b0) $display("FAIL stream_underrun_pulse got=%0b exp=0", underrun); else n_pass++;
    endtask

    // First write is loaded straight from IDLE, so six writes are needed to
    // reach four queued entries plus one rejected write.
    task automatic test_overflow;
        do_reset;
        wr_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wr_duty = 4'(i);
            tick;
            if (i == 5) begin
                n_checks++; if (full !== 1'b1) $display("FAIL ovf_full got=%0b exp=1", full); else n_pass++;
                n_checks++; if (level !== 3'd4) $display("FAIL ovf_level got=%0d exp=4", level); else n_pass++;
                n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_early got=%0b exp=0", overflow); else n_pass++;
            end
        end
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%0b exp=1", overflow); else n_pass++;
        n_checks++; if (level !== 3'd4) $display("FAIL ovf_level_hold got=%0d exp=4", level); else n_pass++;
        n_checks++; if (duty !== 4'd1) $display("FAIL ovf_duty got=%0d exp=1", duty); else n_pass++;
        done = 1'b1; tick; done = 1'b0;
        n_checks++; if (duty !== 4'd2) $display("FAIL ovf_load_duty got=%0d exp=2", duty); else n_pass++;
        n_checks++; if (level !== 3'd3) $display("FAIL ovf_load_level got=%0d exp=3", level); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL ovf_load_full got=%0b exp=0", full); else n_pass++;
        repeat (5) tick;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%0b exp=1", overflow); else n_pass++;
    endtask

    task automatic test_full_pop;
        do_reset;
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_duty = 4'(i);
            tick;
        end
        n_checks++; if (full !== 1'b1) $display("FAIL fullpop_pre_full got=%0b exp=1", full); else n_pass++;
        wr_duty = 4'd15; done = 1'b1; tick;
        wr_en = 1'b0; done = 1'b0;
        n_checks++; if (overflow !== 1'b1) $display("FAIL fullpop_ovf got=%0b exp=1", overflow); else n_pass++;
        n_checks++; if (level !== 3'd3) $display("FAIL fullpop_level got=%0d exp=3", level); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL fullpop_full got=%0b exp=0", full); else n_pass++;
        n_checks++; if (duty !== 4'd2) $display("FAIL fullpop_duty got=%0d exp=2", duty); else n_pass++;
    endtask

    task automatic test_repeat;
        bit go_dropped = 1'b0;
        do_reset;
        repeat_last = 1'b1; wr_en = 1'b1; wr_duty = 4'd9; tick;
        wr_en = 1'b0; tick;
        n_checks++; if (duty !== 4'd9) $display("FAIL rep_load got=%0d exp=9", duty); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            repeat (6) begin tick; if (go !== 1'b1) go_dropped = 1'b1; end
            done = 1'b1; tick; done = 1'b0;
            n_checks++; if (duty !== 4'd9) $display("FAIL rep_duty k=%0d got=%0d exp=9", k, duty); else n_pass++;
            n_checks++; if (go !== 1'b1) $display("FAIL rep_go k=%0d got=%0b exp=1", k, go); else n_pass++;
            n_checks++; if (underrun !== 1'b0) $display("FAIL rep_und k=%0d got=%0b exp=0", k, underrun); else n_pass++;
        end
        n_checks++; if (go_dropped !== 1'b0) $display("FAIL rep_go_continuous got=dropped exp=steady"); else n_pass++;
        repeat_last = 1'b0;
        repeat (6) tick;
        done = 1'b1; tick; done = 1'b0;
        n_checks++; if (underrun !== 1'b1) $display("FAIL rep_stop_und got=%0b exp=1", underrun); else n_pass++;
        n_checks++; if (go !== 1'b0) $display("FAIL rep_stop_go got=%0b exp=0", go); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rep_stop_busy got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_gap;
        int low = 0;
        bit seen_high = 1'b0;
        bit busy_lost = 1'b0;
        do_reset;
        g_wr_en = 1'b1; g_wr_duty = 4'd2; tick;
        g_wr_duty = 4'd4; tick;
        g_wr_en = 1'b0;
        n_checks++; if (g_duty !== 4'd2) $display("FAIL gap_first_duty got=%0d exp=2", g_duty); else n_pass++;
        n_checks++; if (g_go !== 1'b1) $display("FAIL gap_first_go got=%0b exp=1", g_go); else n_pass++;
        repeat (4) tick;
        g_done = 1'b1; tick; g_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (g_go === 1'b0) begin
                low++;
                if (g_busy !== 1'b1) busy_lost = 1'b1;
            end else begin
                seen_high = 1'b1;
                break;
            end
            tick;
        end
        n_checks++; if (seen_high !== 1'b1) $display("FAIL gap_timeout got=low_for_%0d exp=resume", low); else n_pass++;
        n_checks++; if (low !== 5) $display("FAIL gap_low_cycles got=%0d exp=5", low); else n_pass++;
        n_checks++; if (g_duty !== 4'd4) $display("FAIL gap_next_duty got=%0d exp=4", g_duty); else n_pass++;
        n_checks++; if (busy_lost !== 1'b0) $display("FAIL gap_busy got=dropped exp=high"); else n_pass++;
        repeat (3) tick;
        g_done = 1'b1; tick; g_done = 1'b0;
        n_checks++; if (g_underrun !== 1'b1) $display("FAIL gap_stop_und got=%0b exp=1", g_underrun); else n_pass++;
        n_checks++; if (g_go !== 1'b0) $display("FAIL gap_stop_go got=%0b exp=0", g_go); else n_pass++;
        n_checks++; if (g_busy !== 1'b0) $display("FAIL gap_stop_busy got=%0b exp=0", g_busy); else n_pass++;
    endtask

    task automatic test_reset_mid;
        do_reset;
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_duty = 4'(i + 10);
            tick;
        end
        wr_en = 1'b0;
        repeat (3) tick;
        n_checks++; if (level !== 3'd2) $display("FAIL rmid_pre_level got=%0d exp=2", level); else n_pass++;
        n_checks++; if (go !== 1'b1) $display("FAIL rmid_pre_go got=%0b exp=1", go); else n_pass++;
        reset = 1'b1; done = 1'b1; tick;
        n_checks++; if (go !== 1'b0) $display("FAIL rmid_go got=%0b exp=0", go); else n_pass++;
        n_checks++; if (duty !== 4'd0) $display("FAIL rmid_duty got=%0d exp=0", duty); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL rmid_level got=%0d exp=0", level); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0b exp=0", busy); else n_pass++;
        reset = 1'b0; done = 1'b0; tick;
        n_checks++; if (go !== 1'b0) $display("FAIL rmid_after_go got=%0b exp=0", go); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL rmid_after_und got=%0b exp=0", underrun); else n_pass++;
    endtask

    // Reference: a queue of accepted duty words and a running/stopped flag.
    task automatic test_random;
        logic [3:0] q [$];
        bit         m_run = 1'b0;
        logic [3:0] m_duty = 4'd0;
        bit         m_ovf = 1'b0;
        bit         m_und;
        bit         m_full;
        do_reset;
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 99) == 0);
            wr_en       = ($urandom_range(0, 99) < 45);
            wr_duty     = 4'($urandom);
            repeat_last = ($urandom_range(0, 3) == 0);
            done        = ($urandom_range(0, 4) == 0);
            m_und  = 1'b0;
            m_full = (q.size() == 4);
            if (reset) begin
                q.delete();
                m_run = 1'b0; m_duty = 4'd0; m_ovf = 1'b0;
            end else begin
                if (!m_run) begin
                    if (q.size() != 0) begin m_duty = q.pop_front(); m_run = 1'b1; end
                end else if (done) begin
                    if (q.size() != 0) m_duty = q.pop_front();
                    else if (!repeat_last) begin m_run = 1'b0; m_und = 1'b1; end
                end
                if (wr_en) begin
                    if (m_full) m_ovf = 1'b1;
                    else q.push_back(wr_duty);
                end
            end
            tick;
            n_checks++; if (go !== m_run) $display("FAIL rnd_go c=%0d got=%0b exp=%0b", c, go, m_run); else n_pass++;
            n_checks++; if (duty !== m_duty) $display("FAIL rnd_duty c=%0d got=%0d exp=%0d", c, duty, m_duty); else n_pass++;
            n_checks++; if (level !== 3'(q.size())) $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, q.size()); else n_pass++;
            n_checks++; if (full !== (q.size() == 4)) $display("FAIL rnd_full c=%0d got=%0b exp=%0b", c, full, q.size() == 4); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf c=%0d got=%0b exp=%0b", c, overflow, m_ovf); else n_pass++;
            n_checks++; if (underrun !== m_und) $display("FAIL rnd_und c=%0d got=%0b exp=%0b", c, underrun, m_und); else n_pass++;
            n_checks++; if (busy !== m_run) $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, m_run); else n_pass++;
        end
        reset = 1'b0; wr_en = 1'b0; done = 1'b0; repeat_last = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        do_reset;
        test_reset;
        test_stream;
        test_overflow;
        test_full_pop;
        test_repeat;
        test_gap;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
